// File: rtl/sync_fft_feeder_pkg.sv
// Shared types for the synchronizer-to-FFT feeder: FSM state encodings and
// the packet-length normalisation helper.
package sync_fft_feeder_pkg;

  localparam int CFG_W = 8;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_SKIP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE   = 1'b0,
    R_STREAM = 1'b1
  } rd_state_e;

  // A packet length of zero behaves as one symbol per packet.
  function automatic logic [CFG_W-1:0] norm_syms_per_pkt(input logic [CFG_W-1:0] cfg);
    return (cfg == '0) ? CFG_W'(1) : cfg;
  endfunction

endpackage

// File: rtl/sync_pingpong_ram.sv
// Simple dual-port symbol buffer: one write port, one read port with a
// registered 1-cycle read. Address is {bank, index}.
module sync_pingpong_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem_q[rd_addr];
  end

endmodule

// File: rtl/sync_fft_feeder.sv
// Buffers strobed OFDM symbols into a ping-pong RAM and replays each complete
// symbol to the FFT as AXI-Stream, grouping symbols into packets.
module sync_fft_feeder
  import sync_fft_feeder_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N_FFT  = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  input  logic [CFG_W-1:0]  cfg_syms_per_pkt,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              overflow,
  output logic              err_len,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              busy
);

  localparam int IDX_W  = $clog2(N_FFT);
  localparam int ADDR_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FFT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Write side state
  wr_state_e          w_state_q, w_state_d;
  logic               wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [1:0]         full_q, full_d;
  logic               overflow_q, overflow_d;
  logic               err_len_q, err_len_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic               ram_wr_en;
  logic [IDX_W-1:0]   ram_wr_idx;
  logic               set_full;

  // Read side state
  rd_state_e          r_state_q, r_state_d;
  logic               rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic               advance;
  logic               issue;
  logic [IDX_W-1:0]   issue_idx;
  logic [DATA_W-1:0]  ram_rd_data;

  // Pipeline: p1 is the RAM read register, the output register follows it
  logic               vld_p1_q, vld_p1_d;
  logic               first_p1_q, first_p1_d;
  logic               eos_p1_q, eos_p1_d;
  logic               bank_p1_q, bank_p1_d;

  logic [DATA_W-1:0]  tdata_q, tdata_d;
  logic               tvalid_q, tvalid_d;
  logic               tlast_q, tlast_d;
  logic               tuser_q, tuser_d;
  logic               eos_q, eos_d;
  logic               out_bank_q, out_bank_d;
  logic [CFG_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic [CFG_W-1:0]   pkt_cfg_q, pkt_cfg_d;
  logic               clr_full;

  sync_pingpong_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr ({wr_bank_q, ram_wr_idx}),
    .wr_data (s_data),
    .rd_en   (issue),
    .rd_addr ({rd_bank_q, issue_idx}),
    .rd_data (ram_rd_data)
  );

  always_comb begin
    w_state_d  = w_state_q;
    wr_bank_d  = wr_bank_q;
    wr_idx_d   = wr_idx_q;
    overflow_d = 1'b0;
    err_len_d  = 1'b0;
    drop_cnt_d = drop_cnt_q;
    ram_wr_en  = 1'b0;
    ram_wr_idx = wr_idx_q;
    set_full   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_valid) begin
          if (!full_q[wr_bank_q]) begin
            ram_wr_en  = 1'b1;
            ram_wr_idx = '0;
            if (s_last) begin
              err_len_d = 1'b1;
            end else begin
              wr_idx_d  = IDX_W'(1);
              w_state_d = W_FILL;
            end
          end else begin
            overflow_d = 1'b1;
            drop_cnt_d = sat_inc(drop_cnt_q);
            if (!s_last) w_state_d = W_SKIP;
          end
        end
      end
      W_FILL: begin
        if (s_valid) begin
          ram_wr_en = 1'b1;
          wr_idx_d  = wr_idx_q + IDX_W'(1);
          if (s_last) begin
            if (wr_idx_q == LAST_IDX) begin
              set_full  = 1'b1;
              wr_bank_d = ~wr_bank_q;
            end else begin
              err_len_d = 1'b1;
            end
            w_state_d = W_IDLE;
          end else if (wr_idx_q == LAST_IDX) begin
            err_len_d = 1'b1;
            w_state_d = W_SKIP;
          end
        end
      end
      W_SKIP: begin
        if (s_valid && s_last) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // The whole read pipeline moves together whenever the output register can accept.
  assign advance  = !tvalid_q || m_axis_tready;
  assign clr_full = tvalid_q && m_axis_tready && eos_q;

  always_comb begin
    r_state_d = r_state_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    issue     = 1'b0;
    issue_idx = rd_idx_q;
    case (r_state_q)
      R_IDLE: begin
        if (advance && full_q[rd_bank_q]) begin
          issue     = 1'b1;
          issue_idx = '0;
          rd_idx_d  = IDX_W'(1);
          r_state_d = R_STREAM;
        end
      end
      R_STREAM: begin
        if (advance) begin
          issue = 1'b1;
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d  = '0;
            rd_bank_d = ~rd_bank_q;
            r_state_d = R_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    vld_p1_d   = vld_p1_q;
    first_p1_d = first_p1_q;
    eos_p1_d   = eos_p1_q;
    bank_p1_d  = bank_p1_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tuser_d    = tuser_q;
    eos_d      = eos_q;
    out_bank_d = out_bank_q;
    sym_cnt_d  = sym_cnt_q;
    pkt_cfg_d  = pkt_cfg_q;
    if (advance) begin
      vld_p1_d   = issue;
      first_p1_d = (issue_idx == '0);
      eos_p1_d   = (issue_idx == LAST_IDX);
      bank_p1_d  = rd_bank_q;
      tvalid_d   = vld_p1_q;
      if (vld_p1_q) begin
        tdata_d    = ram_rd_data;
        tuser_d    = first_p1_q;
        eos_d      = eos_p1_q;
        out_bank_d = bank_p1_q;
        tlast_d    = 1'b0;
        if (first_p1_q && sym_cnt_q == '0) pkt_cfg_d = norm_syms_per_pkt(cfg_syms_per_pkt);
        if (eos_p1_q) begin
          if (sym_cnt_q == pkt_cfg_q - CFG_W'(1)) begin
            tlast_d   = 1'b1;
            sym_cnt_d = '0;
          end else begin
            sym_cnt_d = sym_cnt_q + CFG_W'(1);
          end
        end
      end
    end
  end

  // Full flags: set only by the write side, cleared only by the read side.
  always_comb begin
    full_d = full_q;
    if (set_full) full_d[wr_bank_q] = 1'b1;
    if (clr_full) full_d[out_bank_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state_q  <= W_IDLE;
      wr_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      full_q     <= '0;
      overflow_q <= 1'b0;
      err_len_q  <= 1'b0;
      drop_cnt_q <= '0;
      r_state_q  <= R_IDLE;
      rd_bank_q  <= 1'b0;
      rd_idx_q   <= '0;
      vld_p1_q   <= 1'b0;
      first_p1_q <= 1'b0;
      eos_p1_q   <= 1'b0;
      bank_p1_q  <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
      eos_q      <= 1'b0;
      out_bank_q <= 1'b0;
      sym_cnt_q  <= '0;
      pkt_cfg_q  <= CFG_W'(1);
    end else begin
      w_state_q  <= w_state_d;
      wr_bank_q  <= wr_bank_d;
      wr_idx_q   <= wr_idx_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      err_len_q  <= err_len_d;
      drop_cnt_q <= drop_cnt_d;
      r_state_q  <= r_state_d;
      rd_bank_q  <= rd_bank_d;
      rd_idx_q   <= rd_idx_d;
      vld_p1_q   <= vld_p1_d;
      first_p1_q <= first_p1_d;
      eos_p1_q   <= eos_p1_d;
      bank_p1_q  <= bank_p1_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
      eos_q      <= eos_d;
      out_bank_q <= out_bank_d;
      sym_cnt_q  <= sym_cnt_d;
      pkt_cfg_q  <= pkt_cfg_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign overflow      = overflow_q;
  assign err_len       = err_len_q;
  assign drop_cnt      = drop_cnt_q;
  assign busy          = full_q[0] | full_q[1] | tvalid_q;

endmodule
